// File: rtl/wrt_ptr_full_lvl.sv
// Write-side pointer/flag block of the dual-clock FIFO: binary/Gray write pointers, full,
// almost_full and fill level. Optional sticky overflow flag under WRT_OVERFLOW_FLAG_EN.
module wrt_ptr_full_lvl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wrt_clk,
  input  logic                  wrt_rst,
  input  logic                  wrt_en,
  input  logic [ADDR_WIDTH:0]   wq2_rd_ptr,
  output logic                  wrt_accept,
  output logic [ADDR_WIDTH-1:0] wrt_addr,
  output logic [ADDR_WIDTH:0]   wrt_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wrt_level
`ifdef WRT_OVERFLOW_FLAG_EN
  ,
  output logic                  wrt_ovf
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  // Inverting the two MSBs of the read Gray pointer gives the write pointer one lap ahead.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [PW-1:0] AF_TH     = PW'(AFULL_THRESH);

  logic [PW-1:0] wrt_bin, bin_next, gray_next, rd_bin, level_next;
  logic          full_next;

  assign wrt_accept = wrt_en & ~full;
  assign wrt_addr   = wrt_bin[ADDR_WIDTH-1:0];
  assign bin_next   = wrt_bin + PW'(wrt_accept);
  assign gray_next  = (bin_next >> 1) ^ bin_next;

  // Gray-to-binary: each bit is the XOR of itself and every bit above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) rd_bin[i] = ^(wq2_rd_ptr >> i);
  end

  assign level_next = bin_next - rd_bin;
  assign full_next  = (gray_next == (wq2_rd_ptr ^ FULL_MASK));

  always_ff @(posedge wrt_clk) begin
    if (wrt_rst) begin
      wrt_bin     <= '0;
      wrt_ptr     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wrt_level   <= '0;
    end else begin
      wrt_bin     <= bin_next;
      wrt_ptr     <= gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AF_TH);
      wrt_level   <= level_next;
    end
  end

`ifdef WRT_OVERFLOW_FLAG_EN
  always_ff @(posedge wrt_clk) begin
    if (wrt_rst)            wrt_ovf <= 1'b0;
    else if (wrt_en & full) wrt_ovf <= 1'b1;
  end
`endif

endmodule
